// File: rtl/subst_code_tx.sv
// subst_code_tx: transmitter for the noun-class code interface.
// Queues 2-bit noun-class requests in a small FIFO and drives the 4-bit class
// code on a,b,c,d (a = MSB). After the receiver raises ready, it pulses ok for
// one cycle. It also tracks a mirror of the receiver's 4-state classifier.
//
// Ports:
//   clock, reset           rising-edge clock, synchronous active-high reset
//   req_valid, req_class   request input (0 concreto, 1 abstrato, 2 nomep, 3 nota_inv)
//   req_ready              FIFO not full
//   a, b, c, d, ok         code bits and one-cycle code-valid strobe
//   ready                  receiver can accept a code
//   mirror_state           mirrored receiver state (0 zero .. 3 three)
//   fim                    one-cycle pulse after the mirror wraps three -> zero
//   err                    sticky flag: a code did not advance the mirror
//   fifo_count             number of queued entries
//
// Build option: when SUBST_STRICT_ORDER_EN is defined, a head entry that would
// not advance the mirror is dropped at DRIVE without an ok strobe.
module subst_code_tx #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid,
    input  logic [1:0]               req_class,
    output logic                     req_ready,
    output logic                     a,
    output logic                     b,
    output logic                     c,
    output logic                     d,
    output logic                     ok,
    input  logic                     ready,
    output logic [1:0]               mirror_state,
    output logic                     fim,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [1:0] CONCRETO = 2'd0;
    localparam logic [1:0] NOTA_INV = 2'd3;
    localparam logic [1:0] M_ZERO   = 2'd0;
    localparam logic [1:0] M_ONE    = 2'd1;
    localparam logic [1:0] M_TWO    = 2'd2;
    localparam logic [1:0] M_THREE  = 2'd3;

    typedef enum logic [1:0] {IDLE, DRIVE, STROBE, GAP} state_t;

    state_t          state_q, state_d;
    logic [1:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [1:0]      cls_q, cls_d;
    logic [3:0]      code_q, code_d;
    logic            ok_q, ok_d;
    logic [1:0]      mirror_q, mirror_d;
    logic            wrap_q, wrap_d;
    logic            fim_q, fim_d;
    logic            err_q, err_d;
    logic [GW-1:0]   gap_q, gap_d;

    logic            push, pop, drop;
    logic [1:0]      mirror_nxt;
    logic            head_bad;

    // Line code for each noun class.
    function automatic logic [3:0] code_of(input logic [1:0] cls);
        case (cls)
            2'd0:    code_of = 4'b0111;
            2'd1:    code_of = 4'b1001;
            2'd2:    code_of = 4'b1010;
            default: code_of = 4'b1100;
        endcase
    endfunction

    // Receiver classifier transition. States zero and one share rules; in
    // both, nota_inv leaves the state unchanged.
    function automatic logic [1:0] mirror_step(input logic [1:0] m, input logic [1:0] cls);
        case (m)
            M_ZERO, M_ONE: mirror_step = (cls == NOTA_INV) ? m : 2'(cls + 2'd1);
            M_TWO:         mirror_step = (cls == 2'd2) ? M_THREE : M_TWO;
            default:       mirror_step = (cls == NOTA_INV) ? M_ZERO : M_THREE;
        endcase
    endfunction

    assign push       = req_valid && req_ready;
    assign pop        = (state_q == IDLE) && (count_q != '0);
    assign mirror_nxt = mirror_step(mirror_q, cls_q);
    // In state one, concreto is a legal self-loop and is not an error.
    assign head_bad   = (mirror_nxt == mirror_q) && !((mirror_q == M_ONE) && (cls_q == CONCRETO));

`ifdef SUBST_STRICT_ORDER_EN
    assign drop = head_bad;
`else
    assign drop = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (count_q != '0) state_d = DRIVE;
            DRIVE:   if (drop) state_d = IDLE;
                     else if (ready) state_d = STROBE;
            STROBE:  state_d = GAP;
            default: if (gap_q == GW'(GAP_CYCLES - 1)) state_d = IDLE;
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        cls_d    = cls_q;
        code_d   = code_q;
        ok_d     = 1'b0;
        mirror_d = mirror_q;
        err_d    = err_q;
        wrap_d   = 1'b0;
        fim_d    = wrap_q;
        gap_d    = gap_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        case (state_q)
            IDLE: begin
                if (pop) begin
                    cls_d  = mem_q[rd_ptr_q];
                    code_d = code_of(mem_q[rd_ptr_q]);
                end
            end
            DRIVE: begin
                if (drop) begin
                    code_d = 4'b0000;
                    err_d  = 1'b1;
                end else if (ready) begin
                    ok_d     = 1'b1;
                    mirror_d = mirror_nxt;
                    err_d    = err_q | head_bad;
                    wrap_d   = (mirror_q == M_THREE) && (mirror_nxt == M_ZERO);
                end
            end
            STROBE: begin
                code_d = 4'b0000;
                gap_d  = '0;
            end
            default: gap_d = gap_q + GW'(1);
        endcase
    end

    // Datapath and FIFO registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cls_q    <= '0;
            code_q   <= '0;
            ok_q     <= 1'b0;
            mirror_q <= M_ZERO;
            wrap_q   <= 1'b0;
            fim_q    <= 1'b0;
            err_q    <= 1'b0;
            gap_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= req_class;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q  <= count_d;
            cls_q    <= cls_d;
            code_q   <= code_d;
            ok_q     <= ok_d;
            mirror_q <= mirror_d;
            wrap_q   <= wrap_d;
            fim_q    <= fim_d;
            err_q    <= err_d;
            gap_q    <= gap_d;
        end
    end

    // Fullness comes from the registered count, so a pop in the same cycle
    // does not re-open the input.
    assign req_ready    = (count_q != CW'(DEPTH));
    assign {a, b, c, d} = code_q;
    assign ok           = ok_q;
    assign mirror_state = mirror_q;
    assign fim          = fim_q;
    assign err          = err_q;
    assign fifo_count   = count_q;

endmodule

// File: tb/tb_subst_code_tx.sv
module tb_subst_code_tx;

    localparam int unsigned DEPTH      = 4;
    localparam int unsigned GAP_CYCLES = 1;

    logic       clock = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [1:0] req_class;
    logic       req_ready;
    logic       a, b, c, d;
    logic       ok;
    logic       ready;
    logic [1:0] mirror_state;
    logic       fim;
    logic       err;
    logic [2:0] fifo_count;
    logic [3:0] abcd;

    int checks   = 0;
    int failures = 0;

    assign abcd = {a, b, c, d};

    always #5 clock = ~clock;

    subst_code_tx #(.DEPTH(DEPTH), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_class(req_class), .req_ready(req_ready),
        .a(a), .b(b), .c(c), .d(d), .ok(ok), .ready(ready),
        .mirror_state(mirror_state), .fim(fim), .err(err), .fifo_count(fifo_count)
    );

    // All tasks start and end just after a falling edge.
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; req_valid = 1'b0; req_class = 2'd0; ready = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic push(input logic [1:0] cls);
        req_valid = 1'b1;
        req_class = cls;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (abcd !== 4'b0000 || ok !== 1'b0) begin
            failures++; $display("FAIL reset_code: abcd=%b ok=%b want 0000 0", abcd, ok);
        end
        checks++;
        if (fim !== 1'b0 || err !== 1'b0 || mirror_state !== 2'b00) begin
            failures++; $display("FAIL reset_flags: fim=%b err=%b mirror=%b want 0 0 00", fim, err, mirror_state);
        end
        checks++;
        if (fifo_count !== 3'd0 || req_ready !== 1'b1) begin
            failures++; $display("FAIL reset_fifo: count=%0d ready=%b want 0 1", fifo_count, req_ready);
        end
    endtask

    task automatic test_single();
        do_reset();
        ready = 1'b1;
        push(2'd0);
        checks++;
        if (fifo_count !== 3'd1 || abcd !== 4'b0000) begin
            failures++; $display("FAIL single_queued: count=%0d abcd=%b want 1 0000", fifo_count, abcd);
        end
        @(negedge clock);
        checks++;
        if (abcd !== 4'b0111 || ok !== 1'b0) begin
            failures++; $display("FAIL single_drive: abcd=%b ok=%b want 0111 0", abcd, ok);
        end
        @(negedge clock);
        checks++;
        if (ok !== 1'b1 || abcd !== 4'b0111 || mirror_state !== 2'b01 || err !== 1'b0) begin
            failures++; $display("FAIL single_strobe: ok=%b abcd=%b mirror=%b err=%b want 1 0111 01 0",
                                 ok, abcd, mirror_state, err);
        end
        @(negedge clock);
        checks++;
        if (ok !== 1'b0 || abcd !== 4'b0000 || fim !== 1'b0) begin
            failures++; $display("FAIL single_gap: ok=%b abcd=%b fim=%b want 0 0000 0", ok, abcd, fim);
        end
    endtask

    task automatic test_sequence();
        logic [1:0] cls   [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        logic [1:0] exp_m [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
        int okn = 0, fimn = 0, fim_cyc = -1, ok4_cyc = -1, last_ok = -100;
        do_reset();
        ready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            req_valid = (cyc < 4);
            req_class = cls[cyc % 4];
            @(posedge clock);
            @(negedge clock);
            if (ok === 1'b1) begin
                if (okn < 4) begin
                    checks++;
                    if (mirror_state !== exp_m[okn]) begin
                        failures++; $display("FAIL seq_mirror%0d: mirror=%b want %b", okn, mirror_state, exp_m[okn]);
                    end
                end
                if (okn > 0) begin
                    checks++;
                    if (cyc - last_ok < 2 + int'(GAP_CYCLES)) begin
                        failures++; $display("FAIL seq_spacing%0d: gap=%0d want >=%0d", okn, cyc - last_ok, 2 + GAP_CYCLES);
                    end
                end
                if (okn == 3) ok4_cyc = cyc;
                last_ok = cyc;
                okn++;
            end
            if (fim === 1'b1) begin
                fimn++;
                fim_cyc = cyc;
            end
        end
        req_valid = 1'b0;
        checks++;
        if (okn != 4 || fimn != 1) begin
            failures++; $display("FAIL seq_counts: oks=%0d fims=%0d want 4 1", okn, fimn);
        end
        checks++;
        if (fim_cyc != ok4_cyc + 1 || ok4_cyc < 0) begin
            failures++; $display("FAIL seq_fim_timing: fim_cyc=%0d want %0d", fim_cyc, ok4_cyc + 1);
        end
        checks++;
        if (err !== 1'b0) begin
            failures++; $display("FAIL seq_err: err=%b want 0", err);
        end
    endtask

    task automatic test_ready_hold();
        int bad = 0;
        do_reset();
        push(2'd0);
        @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            if (abcd !== 4'b0111 || ok !== 1'b0) bad++;
            @(negedge clock);
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL hold_stable: bad_cycles=%0d want 0", bad);
        end
        ready = 1'b1;
        @(negedge clock);
        checks++;
        if (ok !== 1'b1 || abcd !== 4'b0111) begin
            failures++; $display("FAIL hold_release: ok=%b abcd=%b want 1 0111", ok, abcd);
        end
        @(negedge clock);
        checks++;
        if (ok !== 1'b0) begin
            failures++; $display("FAIL hold_single_strobe: ok=%b want 0", ok);
        end
    endtask

    task automatic test_full();
        int acc = 0;
        int after_full = -1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1;
            req_class = 2'(i % 4);
            if (req_ready === 1'b1) acc++;
            @(posedge clock);
            @(negedge clock);
            // The second push lands together with the first pop into DRIVE.
            if (i == 1) begin
                checks++;
                if (fifo_count !== 3'd1) begin
                    failures++; $display("FAIL full_push_pop: count=%0d want 1", fifo_count);
                end
            end
        end
        checks++;
        if (acc != 5 || fifo_count !== 3'd4 || req_ready !== 1'b0) begin
            failures++; $display("FAIL full_refuse: accepted=%0d count=%0d req_ready=%b want 5 4 0",
                                 acc, fifo_count, req_ready);
        end
        ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (fifo_count !== 3'd4) begin
                after_full = int'(fifo_count);
                break;
            end
        end
        req_valid = 1'b0;
        checks++;
        if (after_full != 3) begin
            failures++; $display("FAIL full_pop_no_reopen: count=%0d want 3", after_full);
        end
    endtask

    task automatic test_err();
        int oks = 0;
        bit seen = 1'b0;
        do_reset();
        ready = 1'b1;
        push(2'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (ok === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen || mirror_state !== 2'b10 || err !== 1'b0) begin
            failures++; $display("FAIL err_first: seen=%0d mirror=%b err=%b want 1 10 0", seen, mirror_state, err);
        end
        push(2'd0);
        for (int k = 0; k < 12; k++) begin
            if (ok === 1'b1) oks++;
            @(negedge clock);
        end
`ifdef SUBST_STRICT_ORDER_EN
        checks++;
        if (oks != 0) begin
            failures++; $display("FAIL err_strict_no_ok: oks=%0d want 0", oks);
        end
`else
        checks++;
        if (oks != 1) begin
            failures++; $display("FAIL err_sent: oks=%0d want 1", oks);
        end
`endif
        checks++;
        if (mirror_state !== 2'b10 || err !== 1'b1) begin
            failures++; $display("FAIL err_flag: mirror=%b err=%b want 10 1", mirror_state, err);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        push(2'd0);
        push(2'd1);
        push(2'd2);
        push(2'd3);
        checks++;
        if (fifo_count !== 3'd3) begin
            failures++; $display("FAIL mid_queued: count=%0d want 3", fifo_count);
        end
        ready = 1'b1;
        @(negedge clock);
        checks++;
        if (ok !== 1'b1) begin
            failures++; $display("FAIL mid_strobe: ok=%b want 1", ok);
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (ok !== 1'b0 || abcd !== 4'b0000 || fifo_count !== 3'd0 || mirror_state !== 2'b00 || req_ready !== 1'b1) begin
            failures++; $display("FAIL mid_reset: ok=%b abcd=%b count=%0d mirror=%b req_ready=%b want 0 0000 0 00 1",
                                 ok, abcd, fifo_count, mirror_state, req_ready);
        end
        reset = 1'b0;
        ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_class = 2'd0; ready = 1'b0;
        test_reset();
        test_single();
        test_sequence();
        test_ready_hold();
        test_full();
        test_err();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
